// File: rtl/fwd_pkg.sv
// Shared select codes and FSM encoding for the EX operand forwarding/hazard unit.
package fwd_pkg;

   localparam logic [1:0] FWD_REG   = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } fwd_state_e;

endpackage

// File: rtl/fwd_select.sv
// Priority compare for one EX operand: the newest producer (EX) beats the older one (MEM).
module fwd_select
   import fwd_pkg::*;
#(
   parameter int REG_BITS = 5
) (
   input  logic [REG_BITS-1:0] src_i,
   input  logic                uses_i,
   input  logic                idex_reg_write_i,
   input  logic [REG_BITS-1:0] idex_dest_i,
   input  logic                exmem_reg_write_i,
   input  logic [REG_BITS-1:0] exmem_dest_i,
   output logic [1:0]          sel_o
);

   logic src_nz;

   assign src_nz = (src_i != '0);

   always_comb begin
      sel_o = FWD_REG;
      if (uses_i && idex_reg_write_i && (idex_dest_i == src_i) && src_nz)
         sel_o = FWD_EXMEM;
      else if (exmem_reg_write_i && (exmem_dest_i == src_i) && src_nz)
         sel_o = FWD_MEMWB;
   end

endmodule

// File: rtl/forward_hazard_unit.sv
// Registered EX forwarding selects, load-use stall detection and a saturating stall counter.
// state    | meaning
// ST_RUN   | normal flow, selects track the ID instruction
// ST_STALL | one bubble inserted, the load has moved to MEM
module forward_hazard_unit
   import fwd_pkg::*;
#(
   parameter int REG_BITS = 5,
   parameter int CNT_BITS = 32
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [REG_BITS-1:0] IFID_Rs,
   input  logic [REG_BITS-1:0] IFID_Rt,
   input  logic                IFID_UsesRs,
   input  logic                IFID_UsesRt,
   input  logic                IDEX_RegWrite,
   input  logic                IDEX_MemRead,
   input  logic [REG_BITS-1:0] IDEX_Dest,
   input  logic                EXMEM_RegWrite,
   input  logic [REG_BITS-1:0] EXMEM_Dest,
   input  logic                BranchTaken,
   output logic [1:0]          ForwardA,
   output logic [1:0]          ForwardB,
   output logic                PCWrite,
   output logic                IFIDWrite,
   output logic                IDEX_Bubble,
   output logic                IFID_Flush,
   output logic [CNT_BITS-1:0] StallCount
);

   logic [1:0]          sel_a, sel_b;
   logic                hazard;
   fwd_state_e          state_q, state_d;
   logic [1:0]          fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;

   fwd_select #(.REG_BITS(REG_BITS)) u_sel_a (
      .src_i             (IFID_Rs),
      .uses_i            (IFID_UsesRs),
      .idex_reg_write_i  (IDEX_RegWrite),
      .idex_dest_i       (IDEX_Dest),
      .exmem_reg_write_i (EXMEM_RegWrite),
      .exmem_dest_i      (EXMEM_Dest),
      .sel_o             (sel_a)
   );

   fwd_select #(.REG_BITS(REG_BITS)) u_sel_b (
      .src_i             (IFID_Rt),
      .uses_i            (IFID_UsesRt),
      .idex_reg_write_i  (IDEX_RegWrite),
      .idex_dest_i       (IDEX_Dest),
      .exmem_reg_write_i (EXMEM_RegWrite),
      .exmem_dest_i      (EXMEM_Dest),
      .sel_o             (sel_b)
   );

   assign hazard = IDEX_MemRead && (IDEX_Dest != '0) &&
                   ((IFID_UsesRs && (IFID_Rs == IDEX_Dest)) ||
                    (IFID_UsesRt && (IFID_Rt == IDEX_Dest)));

   assign PCWrite     = ~hazard;
   assign IFIDWrite   = ~hazard;
   assign IDEX_Bubble = hazard;
   // A taken branch is not flushed while stalled; it is re-evaluated once released.
   assign IFID_Flush  = BranchTaken & ~hazard;

   always_comb begin
      state_d = state_q;
      fwd_a_d = sel_a;
      fwd_b_d = sel_b;
      case (state_q)
         ST_RUN: begin
            if (hazard) state_d = ST_STALL;
         end
         ST_STALL: begin
            state_d = hazard ? ST_STALL : ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
      if (hazard) begin
         fwd_a_d = FWD_REG;
         fwd_b_d = FWD_REG;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (hazard && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_RUN;
         fwd_a_q <= FWD_REG;
         fwd_b_q <= FWD_REG;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ForwardA   = fwd_a_q;
   assign ForwardB   = fwd_b_q;
   assign StallCount = cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed-vector bench for forward_hazard_unit, small counter width to reach saturation.
module tb_forward_hazard_unit;

   localparam int RB = 5;
   localparam int CB = 3;

   logic          Clk = 1'b0;
   logic          Reset;
   logic [RB-1:0] IFID_Rs, IFID_Rt, IDEX_Dest, EXMEM_Dest;
   logic          IFID_UsesRs, IFID_UsesRt, IDEX_RegWrite, IDEX_MemRead;
   logic          EXMEM_RegWrite, BranchTaken;
   logic [1:0]    ForwardA, ForwardB;
   logic          PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush;
   logic [CB-1:0] StallCount;

   int n_checks = 0;
   int n_fail   = 0;

   forward_hazard_unit #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .IFID_Rs        (IFID_Rs),
      .IFID_Rt        (IFID_Rt),
      .IFID_UsesRs    (IFID_UsesRs),
      .IFID_UsesRt    (IFID_UsesRt),
      .IDEX_RegWrite  (IDEX_RegWrite),
      .IDEX_MemRead   (IDEX_MemRead),
      .IDEX_Dest      (IDEX_Dest),
      .EXMEM_RegWrite (EXMEM_RegWrite),
      .EXMEM_Dest     (EXMEM_Dest),
      .BranchTaken    (BranchTaken),
      .ForwardA       (ForwardA),
      .ForwardB       (ForwardB),
      .PCWrite        (PCWrite),
      .IFIDWrite      (IFIDWrite),
      .IDEX_Bubble    (IDEX_Bubble),
      .IFID_Flush     (IFID_Flush),
      .StallCount     (StallCount)
   );

   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      IFID_Rs = '0; IFID_Rt = '0; IFID_UsesRs = 1'b0; IFID_UsesRt = 1'b0;
      IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0; IDEX_Dest = '0;
      EXMEM_RegWrite = 1'b0; EXMEM_Dest = '0; BranchTaken = 1'b0;
   endtask

   task automatic set_load(input logic [RB-1:0] d);
      IDEX_RegWrite = 1'b1; IDEX_MemRead = 1'b1; IDEX_Dest = d;
   endtask

   initial begin
      idle();
      Reset = 1'b1;
      tick(); tick();
      Reset = 1'b0;
      check_val("rst_fwda", ForwardA, 0);
      check_val("rst_fwdb", ForwardB, 0);
      check_val("rst_cnt", StallCount, 0);
      check_val("rst_pcw", PCWrite, 1);
      check_val("rst_ifidw", IFIDWrite, 1);
      check_val("rst_bubble", IDEX_Bubble, 0);
      check_val("rst_flush", IFID_Flush, 0);

      // EX writes $3, ID reads rs=$3
      IDEX_RegWrite = 1'b1; IDEX_Dest = 5'd3;
      IFID_Rs = 5'd3; IFID_UsesRs = 1'b1; IFID_Rt = 5'd7; IFID_UsesRt = 1'b1;
      tick();
      check_val("ex_fwd_a", ForwardA, 1);
      check_val("ex_fwd_b", ForwardB, 0);

      // EX and MEM both write $5, newest wins
      idle();
      IDEX_RegWrite = 1'b1; IDEX_Dest = 5'd5;
      EXMEM_RegWrite = 1'b1; EXMEM_Dest = 5'd5;
      IFID_Rs = 5'd1; IFID_UsesRs = 1'b1; IFID_Rt = 5'd5; IFID_UsesRt = 1'b1;
      tick();
      check_val("prio_fwd_b", ForwardB, 1);
      check_val("prio_fwd_a", ForwardA, 0);

      IDEX_RegWrite = 1'b0;
      tick();
      check_val("mem_fwd_b", ForwardB, 2);

      // unused operand ignores the EX producer
      idle();
      IDEX_RegWrite = 1'b1; IDEX_Dest = 5'd6; IFID_Rs = 5'd6; IFID_UsesRs = 1'b0;
      tick();
      check_val("unused_fwd_a", ForwardA, 0);

      // load-use on rs=$4
      idle();
      set_load(5'd4); IFID_Rs = 5'd4; IFID_UsesRs = 1'b1;
      EXMEM_RegWrite = 1'b1; EXMEM_Dest = 5'd4;
      #1;
      check_val("lu_pcw", PCWrite, 0);
      check_val("lu_ifidw", IFIDWrite, 0);
      check_val("lu_bubble", IDEX_Bubble, 1);
      tick();
      check_val("lu_fwd_a", ForwardA, 0);
      check_val("lu_cnt", StallCount, 1);
      IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0; IDEX_Dest = '0;
      #1;
      check_val("lu_rel_bubble", IDEX_Bubble, 0);
      check_val("lu_rel_pcw", PCWrite, 1);
      tick();
      check_val("lu_mem_fwd_a", ForwardA, 2);
      check_val("lu_cnt_hold", StallCount, 1);

      // $0 never forwards and never stalls
      idle();
      IDEX_RegWrite = 1'b1; IDEX_Dest = 5'd0; IFID_Rs = 5'd0; IFID_UsesRs = 1'b1;
      EXMEM_RegWrite = 1'b1; EXMEM_Dest = 5'd0;
      tick();
      check_val("zero_fwd_a", ForwardA, 0);
      set_load(5'd0);
      #1;
      check_val("zero_lw_bubble", IDEX_Bubble, 0);

      // branch together with hazard: stall wins, flush next cycle
      idle();
      set_load(5'd8); IFID_Rt = 5'd8; IFID_UsesRt = 1'b1; BranchTaken = 1'b1;
      #1;
      check_val("br_hz_flush", IFID_Flush, 0);
      check_val("br_hz_bubble", IDEX_Bubble, 1);
      tick();
      check_val("br_cnt", StallCount, 2);
      IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0; IDEX_Dest = '0;
      #1;
      check_val("br_flush", IFID_Flush, 1);
      tick();

      // reset asserted while stalled
      idle();
      set_load(5'd9); IFID_Rs = 5'd9; IFID_UsesRs = 1'b1;
      tick();
      check_val("st_cnt", StallCount, 3);
      Reset = 1'b1;
      EXMEM_RegWrite = 1'b1; EXMEM_Dest = 5'd10; IFID_Rt = 5'd10; IFID_UsesRt = 1'b1;
      #1;
      check_val("rst_st_bubble", IDEX_Bubble, 1);
      tick();
      check_val("rst_st_fwda", ForwardA, 0);
      check_val("rst_st_fwdb", ForwardB, 0);
      check_val("rst_st_cnt", StallCount, 0);
      Reset = 1'b0;
      IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0; IDEX_Dest = '0;
      tick();
      check_val("post_rst_fwdb", ForwardB, 2);

      // repeated stalls saturate the counter
      idle();
      set_load(5'd11); IFID_Rs = 5'd11; IFID_UsesRs = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check_val("sat_reach", StallCount, 7);
      tick();
      check_val("sat_hold", StallCount, 7);
      tick();
      check_val("sat_hold2", StallCount, 7);
      check_val("sat_fwd_a", ForwardA, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
